// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-requester sequencer for a 64-byte big-endian DataMemory.
// Ports:
//   CLK, RST          clock; asynchronous active-low reset
//   a_*/b_*           requester A (CPU) and B (debug/DMA): req/we/addr/wdata in, gnt/done/err out
//   rdata             last word read, valid from the done cycle of a read
//   mem_*             registered strobes, address and write data to DataMemory; mem_dataout back
module data_mem_arbiter #(
  parameter int MEM_BYTES   = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [31:0] rdata,
  output logic        mem_RD,
  output logic        mem_WR,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_dataout
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        a_done_q, a_done_d, b_done_q, b_done_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [31:0] rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        pick_b, sel_we, illegal;
  logic [31:0] sel_addr, sel_wdata;
  // last_b_q doubles as the record of who owns the in-flight access
  assign pick_b    = b_req && (!a_req || !last_b_q);
  assign sel_we    = pick_b ? b_we : a_we;
  assign sel_addr  = pick_b ? b_addr : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;
  assign illegal   = (sel_addr > 32'(MEM_BYTES - 4)) || (CHECK_ALIGN && sel_addr[1:0] != 2'b00);
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: if (a_req || b_req) begin
        last_b_d = pick_b;
        a_gnt_d  = !pick_b;
        b_gnt_d  = pick_b;
        if (illegal) begin
          // rejected requests skip ACCESS: gnt, done and err share one cycle
          state_d  = RESP;
          a_done_d = !pick_b;
          b_done_d = pick_b;
          a_err_d  = !pick_b;
          b_err_d  = pick_b;
        end else begin
          state_d     = ACCESS;
          mem_addr_d  = sel_addr;
          mem_rd_d    = !sel_we;
          mem_wr_d    = sel_we;
          mem_wdata_d = sel_we ? sel_wdata : mem_wdata_q;
        end
      end
      ACCESS: begin
        state_d  = RESP;
        rdata_d  = mem_rd_q ? mem_dataout : rdata_q;
        a_done_d = !last_b_q;
        b_done_d = last_b_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end
  assign a_gnt         = a_gnt_q;
  assign b_gnt         = b_gnt_q;
  assign a_done        = a_done_q;
  assign b_done        = b_done_q;
  assign a_err         = a_err_q;
  assign b_err         = b_err_q;
  assign rdata         = rdata_q;
  assign mem_RD        = mem_rd_q;
  assign mem_WR        = mem_wr_q;
  assign mem_address   = mem_addr_q;
  assign mem_writeData = mem_wdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed vector table plus corner-case sequences for data_mem_arbiter.
module tb_data_mem_arbiter;
  logic        CLK = 1'b0, RST = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_RD, mem_WR;
  logic [31:0] rdata, mem_address, mem_writeData, mem_dataout;
  logic        x_req = 0, x_we = 0;
  logic [31:0] x_addr = 0, x_wdata = 0;
  logic        x_gnt, x_done, x_err, y_gnt, y_done, y_err, x_rd, x_wr;
  logic [31:0] x_rdata, x_maddr, x_mwd, x_dout;
  logic [7:0]  m0 [64];
  logic [7:0]  m1 [64];
  int          total = 0, passed = 0;
  logic [31:0] last_rd = 0;

  always #5 CLK = ~CLK;

  data_mem_arbiter u0 (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err),
    .rdata(rdata), .mem_RD(mem_RD), .mem_WR(mem_WR),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_dataout(mem_dataout)
  );

  data_mem_arbiter #(.MEM_BYTES(64), .CHECK_ALIGN(1'b0)) u1 (
    .CLK(CLK), .RST(RST),
    .a_req(x_req), .a_we(x_we), .a_addr(x_addr), .a_wdata(x_wdata),
    .a_gnt(x_gnt), .a_done(x_done), .a_err(x_err),
    .b_req(1'b0), .b_we(1'b0), .b_addr(32'h0), .b_wdata(32'h0),
    .b_gnt(y_gnt), .b_done(y_done), .b_err(y_err),
    .rdata(x_rdata), .mem_RD(x_rd), .mem_WR(x_wr),
    .mem_address(x_maddr), .mem_writeData(x_mwd), .mem_dataout(x_dout)
  );

  // big-endian byte memories, level-sensitive read, write on posedge
  assign mem_dataout = mem_RD ? {m0[mem_address[5:0]], m0[mem_address[5:0] + 6'd1],
                                 m0[mem_address[5:0] + 6'd2], m0[mem_address[5:0] + 6'd3]} : 32'h0;
  assign x_dout = x_rd ? {m1[x_maddr[5:0]], m1[x_maddr[5:0] + 6'd1],
                          m1[x_maddr[5:0] + 6'd2], m1[x_maddr[5:0] + 6'd3]} : 32'h0;
  always @(posedge CLK) begin
    if (mem_WR) begin
      m0[mem_address[5:0]]        <= mem_writeData[31:24];
      m0[mem_address[5:0] + 6'd1] <= mem_writeData[23:16];
      m0[mem_address[5:0] + 6'd2] <= mem_writeData[15:8];
      m0[mem_address[5:0] + 6'd3] <= mem_writeData[7:0];
    end
    if (x_wr) begin
      m1[x_maddr[5:0]]        <= x_mwd[31:24];
      m1[x_maddr[5:0] + 6'd1] <= x_mwd[23:16];
      m1[x_maddr[5:0] + 6'd2] <= x_mwd[15:8];
      m1[x_maddr[5:0] + 6'd3] <= x_mwd[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        ub;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  // one access from a single requester; req is dropped right after gnt
  task automatic txn(input vec_t v);
    int n = 0;
    @(negedge CLK);
    if (v.ub) begin b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; end
    else begin a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; end
    do begin @(negedge CLK); n++; end while (!(v.ub ? b_gnt : a_gnt) && n < 5);
    chk("gnt_latency", 32'(n), 32'd1);
    chk("other_gnt", 32'(v.ub ? a_gnt : b_gnt), 32'd0);
    a_req = 0; b_req = 0;
    if (v.eerr) begin
      chk("err_done", 32'(v.ub ? b_done : a_done), 32'd1);
      chk("err_flag", 32'(v.ub ? b_err : a_err), 32'd1);
      chk("err_strobes", {30'd0, mem_RD, mem_WR}, 32'd0);
      chk("err_rdata", rdata, last_rd);
    end else begin
      chk("acc_strobes", {30'd0, mem_RD, mem_WR}, {30'd0, !v.we, v.we});
      chk("acc_addr", mem_address, v.addr);
      if (v.we) chk("acc_wdata", mem_writeData, v.wdata);
      chk("acc_no_done", 32'(v.ub ? b_done : a_done), 32'd0);
      @(negedge CLK);
      chk("done", 32'(v.ub ? b_done : a_done), 32'd1);
      chk("done_err", 32'(v.ub ? b_err : a_err), 32'd0);
      chk("resp_strobes", {30'd0, mem_RD, mem_WR}, 32'd0);
      if (!v.we) last_rd = v.erd;
      chk("rdata", rdata, last_rd);
    end
  endtask

  initial begin
    vec_t vt [12];
    int   gc [4];
    logic gw [4];
    int   ng, cyc;
    logic both;
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [12];
    int   gc [4];
    logic gw [4];
    int   ng, cyc;
    logic both;
    for (int i = 0; i < 64; i++) begin m0[i] = 8'(i); m1[i] = 8'(i); end
    vt[0]  = '{0, 1, 32'd8,          32'hDEADBEEF, 0, 32'h0};
    vt[1]  = '{0, 0, 32'd8,          32'h0,        0, 32'hDEADBEEF};
    vt[2]  = '{1, 0, 32'd61,         32'h0,        1, 32'h0};
    vt[3]  = '{1, 0, 32'h0000_0100,  32'h0,        1, 32'h0};
    vt[4]  = '{0, 1, 32'd6,          32'h12345678, 1, 32'h0};
    vt[5]  = '{1, 1, 32'd4,          32'h11223344, 0, 32'h0};
    vt[6]  = '{1, 0, 32'd4,          32'h0,        0, 32'h11223344};
    vt[7]  = '{0, 0, 32'd60,         32'h0,        0, 32'h3C3D3E3F};
    vt[8]  = '{0, 0, 32'd64,         32'h0,        1, 32'h0};
    vt[9]  = '{0, 1, 32'hFFFF_FFFC,  32'h55555555, 1, 32'h0};
    vt[10] = '{0, 1, 32'd12,         32'hCAFEF00D, 0, 32'h0};
    vt[11] = '{1, 0, 32'd12,         32'h0,        0, 32'hCAFEF00D};
    #12;
    chk("rst_outs", {26'd0, a_gnt, a_done, a_err, b_gnt, mem_RD, mem_WR}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_maddr", mem_address, 32'd0);
    chk("rst_mwdata", mem_writeData, 32'd0);
    @(negedge CLK); RST = 1;

    // both requesters held: grants alternate starting with A
    @(negedge CLK);
    a_req = 1; a_we = 0; a_addr = 0; b_req = 1; b_we = 0; b_addr = 4;
    ng = 0; cyc = 0; both = 0;
    while (ng < 4 && cyc < 40) begin
      @(negedge CLK); cyc++;
      if (a_gnt && b_gnt) both = 1;
      if (a_gnt || b_gnt) begin gc[ng] = cyc; gw[ng] = b_gnt; ng++; end
    end
    a_req = 0; b_req = 0;
    chk("fair_count", 32'(ng), 32'd4);
    chk("fair_dual", 32'(both), 32'd0);
    chk("fair_order", {28'd0, gw[0], gw[1], gw[2], gw[3]}, 32'b0101);
    chk("fair_gap", 32'((gc[1] - gc[0] >= 3) && (gc[2] - gc[1] >= 3) && (gc[3] - gc[2] >= 3)), 32'd1);
    repeat (3) @(negedge CLK);
    last_rd = 32'h04050607;

    for (int i = 0; i < 12; i++) txn(vt[i]);
    chk("early_drop_mem", {m0[12], m0[13], m0[14], m0[15]}, 32'hCAFEF00D);
    chk("misalign_untouched", {m0[4], m0[5], m0[6], m0[7]}, 32'h11223344);

    // unaligned write and read on the instance without alignment checking
    @(negedge CLK);
    x_req = 1; x_we = 1; x_addr = 6; x_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    chk("na_gnt", {30'd0, x_gnt, x_wr}, 32'b11);
    x_req = 0;
    @(negedge CLK);
    chk("na_wdone", {30'd0, x_done, x_err}, 32'b10);
    @(negedge CLK);
    x_req = 1; x_we = 0; x_addr = 4;
    @(negedge CLK);
    chk("na_rd", {30'd0, x_rd, x_wr}, 32'b10);
    x_req = 0;
    @(negedge CLK);
    chk("na_rdone", {30'd0, x_done, x_err}, 32'b10);
    chk("na_rdata", x_rdata, 32'h0405DEAD);

    // reset while a write strobe is high
    @(negedge CLK);
    a_req = 1; a_we = 1; a_addr = 16; a_wdata = 32'hA5A5A5A5;
    @(posedge CLK); #2;
    chk("rst_mid_wr_before", 32'(mem_WR), 32'd1);
    RST = 0; #1;
    chk("rst_mid_wr_after", {30'd0, mem_WR, a_gnt}, 32'd0);
    a_req = 0;
    @(negedge CLK);
    chk("rst_mid_no_done", {30'd0, a_done, a_err}, 32'd0);
    RST = 1;
    @(negedge CLK);
    chk("rst_mid_no_done2", 32'(a_done), 32'd0);
    chk("rst_mid_mem", {m0[16], m0[17], m0[18], m0[19]}, 32'h10111213);
    chk("rst_mid_rdata", rdata, 32'd0);
    a_req = 1; a_we = 0; a_addr = 20; b_req = 1; b_we = 0; b_addr = 24;
    ng = 0;
    do begin @(negedge CLK); ng++; end while (!(a_gnt || b_gnt) && ng < 5);
    chk("post_rst_winner", {30'd0, a_gnt, b_gnt}, 32'b10);
    a_req = 0; b_req = 0;
    @(negedge CLK);
    chk("post_rst_done", {30'd0, a_done, a_err}, 32'b10);
    chk("post_rst_rdata", rdata, 32'h14151617);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
